// File: rtl/clock_defs.sv
// Shared clock definitions: controller state encodings, field limits and time-word layout.
// Used by the setup controller and the running time counter.
package clock_defs;

    typedef enum logic [3:0] {
        ST_RUN      = 4'd0,
        ST_SET_HOUR = 4'd1,
        ST_SET_MIN  = 4'd2,
        ST_SET_SEC  = 4'd3,
        ST_TZ_SETUP = 4'd4
    } state_t;

    localparam int TIME_W   = 18;
    localparam int FIELD_W  = 6;
    localparam int TZ_W     = 5;
    localparam int HOUR_LSB = 12;
    localparam int MIN_LSB  = 6;
    localparam int SEC_LSB  = 0;

    localparam logic [FIELD_W-1:0]     HOUR_MAX = 6'd23;
    localparam logic [FIELD_W-1:0]     MIN_MAX  = 6'd59;
    localparam logic [FIELD_W-1:0]     SEC_MAX  = 6'd59;
    localparam logic signed [TZ_W-1:0] TZ_MIN   = -5'sd12;
    localparam logic signed [TZ_W-1:0] TZ_MAX   = 5'sd14;

    function automatic logic [FIELD_W-1:0] wrap_step(input logic [FIELD_W-1:0] v,
                                                     input logic [FIELD_W-1:0] max,
                                                     input logic up);
        if (up)
            return (v >= max) ? '0 : v + 6'd1;
        else
            return (v == '0) ? max : v - 6'd1;
    endfunction

    function automatic logic signed [TZ_W-1:0] tz_step(input logic signed [TZ_W-1:0] v,
                                                       input logic up);
        if (up)
            return (v >= TZ_MAX) ? TZ_MIN : v + 5'sd1;
        else
            return (v <= TZ_MIN) ? TZ_MAX : v - 5'sd1;
    endfunction

    // Out-of-range fields from the running counter are edited from zero.
    function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v,
                                                       input logic [FIELD_W-1:0] max);
        return (v > max) ? '0 : v;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button; registered pulse, history resets high
// so a button held through reset must be released before it can act.
module btn_edge (
    input  logic CLK,
    input  logic RESETN,
    input  logic btn_i,
    output logic rise_o
);

    logic hist_q;
    logic rise_q;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hist_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            hist_q <= btn_i;
            rise_q <= btn_i & ~hist_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/clock_setup_ctrl.sv
// Time/timezone setup controller: button-driven edit of hour, minute, second and timezone
// with commit strobe to the time counter and inactivity timeout.
//
// state       | meaning
// ------------+--------------------------------------------------
// ST_RUN      | clock running, only MODE (enter edit) is accepted
// ST_SET_HOUR | UP/DOWN edit hour field
// ST_SET_MIN  | UP/DOWN edit minute field
// ST_SET_SEC  | UP/DOWN edit second field
// ST_TZ_SETUP | UP/DOWN edit timezone offset
module clock_setup_ctrl
    import clock_defs::*;
#(
    parameter int TIMEOUT_S = 10
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                TICK,
    input  logic                BTN_MODE,
    input  logic                BTN_UP,
    input  logic                BTN_DOWN,
    input  logic                BTN_OK,
    input  logic [TIME_W-1:0]   CUR_TIME,
    output logic [3:0]          STATE,
    output logic                LOAD,
    output logic [TIME_W-1:0]   LOAD_TIME,
    output logic [TZ_W-1:0]     TZ_OFS
);

    logic mode_r, up_r, dn_r, ok_r;

    btn_edge u_edge_mode (.CLK(CLK), .RESETN(RESETN), .btn_i(BTN_MODE), .rise_o(mode_r));
    btn_edge u_edge_up   (.CLK(CLK), .RESETN(RESETN), .btn_i(BTN_UP),   .rise_o(up_r));
    btn_edge u_edge_down (.CLK(CLK), .RESETN(RESETN), .btn_i(BTN_DOWN), .rise_o(dn_r));
    btn_edge u_edge_ok   (.CLK(CLK), .RESETN(RESETN), .btn_i(BTN_OK),   .rise_o(ok_r));

    state_t                  state_q, state_d;
    logic [FIELD_W-1:0]      eh_q, eh_d, em_q, em_d, es_q, es_d;
    logic signed [TZ_W-1:0]  et_q, et_d, tz_q, tz_d;
    logic [5:0]              tmo_q, tmo_d;
    logic                    load_q, load_d;

    logic act_ok, act_mode, act_up, any_act;

    assign act_ok   = ok_r;
    assign act_mode = mode_r & ~ok_r;
    assign act_up   = up_r & ~ok_r & ~mode_r;
    assign any_act  = ok_r | mode_r | up_r | dn_r;

    always_comb begin
        state_d = state_q;
        eh_d    = eh_q;
        em_d    = em_q;
        es_d    = es_q;
        et_d    = et_q;
        tz_d    = tz_q;
        tmo_d   = tmo_q;
        load_d  = 1'b0;

        case (state_q)
            ST_RUN: begin
                tmo_d = '0;
                if (act_mode) begin
                    state_d = ST_SET_HOUR;
                    eh_d    = clamp_field(CUR_TIME[HOUR_LSB +: FIELD_W], HOUR_MAX);
                    em_d    = clamp_field(CUR_TIME[MIN_LSB  +: FIELD_W], MIN_MAX);
                    es_d    = clamp_field(CUR_TIME[SEC_LSB  +: FIELD_W], SEC_MAX);
                    et_d    = tz_q;
                end
            end
            ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC, ST_TZ_SETUP: begin
                if (any_act) begin
                    // An accepted action restarts the timeout even if TICK coincides.
                    tmo_d = '0;
                    if (act_ok) begin
                        load_d  = 1'b1;
                        tz_d    = et_q;
                        state_d = ST_RUN;
                    end else if (act_mode) begin
                        case (state_q)
                            ST_SET_HOUR: state_d = ST_SET_MIN;
                            ST_SET_MIN:  state_d = ST_SET_SEC;
                            ST_SET_SEC:  state_d = ST_TZ_SETUP;
                            default:     state_d = ST_SET_HOUR;
                        endcase
                    end else begin
                        case (state_q)
                            ST_SET_HOUR: eh_d = wrap_step(eh_q, HOUR_MAX, act_up);
                            ST_SET_MIN:  em_d = wrap_step(em_q, MIN_MAX, act_up);
                            ST_SET_SEC:  es_d = wrap_step(es_q, SEC_MAX, act_up);
                            default:     et_d = tz_step(et_q, act_up);
                        endcase
                    end
                end else if (TICK) begin
                    if (({1'b0, tmo_q} + 7'd1) >= 7'(TIMEOUT_S)) begin
                        state_d = ST_RUN;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                tmo_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_RUN;
            eh_q    <= '0;
            em_q    <= '0;
            es_q    <= '0;
            et_q    <= '0;
            tz_q    <= '0;
            tmo_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            eh_q    <= eh_d;
            em_q    <= em_d;
            es_q    <= es_d;
            et_q    <= et_d;
            tz_q    <= tz_d;
            tmo_q   <= tmo_d;
            load_q  <= load_d;
        end
    end

    assign STATE     = state_q;
    assign LOAD      = load_q;
    assign LOAD_TIME = {eh_q, em_q, es_q};
    assign TZ_OFS    = tz_q;

endmodule

// File: tb/tb_clock_setup_ctrl.sv
// Self-checking bench for clock_setup_ctrl: directed scenarios plus random button/tick
// sequences compared against an action-level model of the editor.
module tb_clock_setup_ctrl;

    localparam int TMO    = 3;
    localparam int B_OK   = 1;
    localparam int B_MODE = 2;
    localparam int B_UP   = 4;
    localparam int B_DN   = 8;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        TICK = 1'b0;
    logic        BTN_MODE = 1'b0, BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_OK = 1'b0;
    logic [17:0] CUR_TIME = '0;
    logic [3:0]  STATE;
    logic        LOAD;
    logic [17:0] LOAD_TIME;
    logic [4:0]  TZ_OFS;

    int errors = 0;
    int checks = 0;
    int load_total = 0;

    // Model: mode 0=run, 1=hour, 2=min, 3=sec, 4=tz; fields kept as plain integers.
    int m_mode, m_h, m_m, m_s, m_et, m_tz, m_cnt, exp_loads;

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (LOAD === 1'b1) load_total++;

    clock_setup_ctrl #(.TIMEOUT_S(TMO)) dut (
        .CLK(CLK), .RESETN(RESETN), .TICK(TICK),
        .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_OK(BTN_OK),
        .CUR_TIME(CUR_TIME), .STATE(STATE), .LOAD(LOAD),
        .LOAD_TIME(LOAD_TIME), .TZ_OFS(TZ_OFS)
    );

    function automatic logic [17:0] exp_time();
        return {6'(m_h), 6'(m_m), 6'(m_s)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_et = 0; m_tz = 0; m_cnt = 0; exp_loads = 0;
    endtask

    task automatic model_action(input int mask);
        int h, m, s, d;
        exp_loads = 0;
        h = int'(CUR_TIME[17:12]);
        m = int'(CUR_TIME[11:6]);
        s = int'(CUR_TIME[5:0]);
        if (mask == 0) return;
        if (m_mode == 0) begin
            if ((mask & B_MODE) != 0 && (mask & B_OK) == 0) begin
                m_mode = 1;
                m_h = (h > 23) ? 0 : h;
                m_m = (m > 59) ? 0 : m;
                m_s = (s > 59) ? 0 : s;
                m_et = m_tz;
                m_cnt = 0;
            end
        end else begin
            m_cnt = 0;
            if ((mask & B_OK) != 0) begin
                exp_loads = 1;
                m_tz = m_et;
                m_mode = 0;
            end else if ((mask & B_MODE) != 0) begin
                m_mode = (m_mode % 4) + 1;
            end else begin
                d = ((mask & B_UP) != 0) ? 1 : -1;
                case (m_mode)
                    1: m_h = (m_h + d + 24) % 24;
                    2: m_m = (m_m + d + 60) % 60;
                    3: m_s = (m_s + d + 60) % 60;
                    default: m_et = ((m_et + 12 + d + 27) % 27) - 12;
                endcase
            end
        end
    endtask

    task automatic model_tick();
        if (m_mode != 0) begin
            m_cnt++;
            if (m_cnt >= TMO) begin
                m_mode = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic drive(input int mask);
        BTN_OK   = mask[0];
        BTN_MODE = mask[1];
        BTN_UP   = mask[2];
        BTN_DOWN = mask[3];
    endtask

    task automatic press(input int mask, input int hold, output int loads);
        loads = 0;
        @(negedge CLK); drive(mask);
        repeat (hold) begin @(negedge CLK); if (LOAD === 1'b1) loads++; end
        drive(0);
        repeat (3) begin @(negedge CLK); if (LOAD === 1'b1) loads++; end
        model_action(mask);
    endtask

    task automatic tick();
        @(negedge CLK); TICK = 1'b1;
        @(negedge CLK); TICK = 1'b0;
        model_tick();
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", STATE); end
        checks++; if (LOAD !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", LOAD); end
        checks++; if (LOAD_TIME !== 18'd0) begin errors++; $display("FAIL reset_load_time: got %h expected 0", LOAD_TIME); end
        checks++; if (TZ_OFS !== 5'd0) begin errors++; $display("FAIL reset_tz: got %b expected 0", TZ_OFS); end
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_commit();
        int l;
        CUR_TIME = {6'd10, 6'd20, 6'd30};
        press(B_MODE, 1, l);
        checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL commit_enter: got %0d expected 1", STATE); end
        checks++; if (LOAD_TIME !== {6'd10, 6'd20, 6'd30}) begin errors++; $display("FAIL commit_capture: got %h expected %h", LOAD_TIME, {6'd10, 6'd20, 6'd30}); end
        press(B_UP, 1, l);
        press(B_UP, 2, l);
        press(B_OK, 1, l);
        checks++; if (l !== 1) begin errors++; $display("FAIL commit_load_cycles: got %0d expected 1", l); end
        checks++; if (LOAD_TIME !== {6'd12, 6'd20, 6'd30}) begin errors++; $display("FAIL commit_time: got %h expected %h", LOAD_TIME, {6'd12, 6'd20, 6'd30}); end
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL commit_state: got %0d expected 0", STATE); end
    endtask

    task automatic test_wrap();
        int l;
        CUR_TIME = {6'd0, 6'd59, 6'd5};
        press(B_MODE, 1, l);
        press(B_DN, 1, l);
        checks++; if (LOAD_TIME[17:12] !== 6'd23) begin errors++; $display("FAIL hour_wrap_down: got %0d expected 23", LOAD_TIME[17:12]); end
        press(B_MODE, 1, l);
        press(B_UP, 1, l);
        checks++; if (LOAD_TIME[11:6] !== 6'd0) begin errors++; $display("FAIL min_wrap_up: got %0d expected 0", LOAD_TIME[11:6]); end
        press(B_MODE, 1, l);
        press(B_MODE, 1, l);
        checks++; if (STATE !== 4'd4) begin errors++; $display("FAIL tz_state: got %0d expected 4", STATE); end
        repeat (15) press(B_UP, 1, l);
        press(B_OK, 1, l);
        checks++; if (TZ_OFS !== 5'b10100) begin errors++; $display("FAIL tz_wrap_up: got %b expected 10100", TZ_OFS); end
        press(B_MODE, 1, l);
        repeat (3) press(B_MODE, 1, l);
        press(B_DN, 1, l);
        press(B_OK, 1, l);
        checks++; if (TZ_OFS !== 5'b01110) begin errors++; $display("FAIL tz_wrap_down: got %b expected 01110", TZ_OFS); end
        checks++; if (TZ_OFS !== 5'(m_tz)) begin errors++; $display("FAIL tz_model: got %b expected %b", TZ_OFS, 5'(m_tz)); end
    endtask

    task automatic test_timeout();
        int l, base;
        CUR_TIME = {6'd5, 6'd7, 6'd9};
        press(B_MODE, 1, l);
        press(B_MODE, 1, l);
        base = load_total;
        tick(); tick();
        @(negedge CLK); drive(B_UP);
        @(negedge CLK); TICK = 1'b1;
        @(negedge CLK); TICK = 1'b0; drive(0);
        repeat (2) @(negedge CLK);
        model_action(B_UP);
        checks++; if (LOAD_TIME !== exp_time()) begin errors++; $display("FAIL tick_with_action_time: got %h expected %h", LOAD_TIME, exp_time()); end
        tick(); tick();
        checks++; if (STATE !== 4'd2) begin errors++; $display("FAIL timeout_early: got %0d expected 2", STATE); end
        tick();
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL timeout_state: got %0d expected 0", STATE); end
        checks++; if (load_total !== base) begin errors++; $display("FAIL timeout_no_load: got %0d loads expected 0", load_total - base); end
        checks++; if (TZ_OFS !== 5'd14) begin errors++; $display("FAIL timeout_tz: got %b expected 01110", TZ_OFS); end
    endtask

    task automatic test_priority_hold();
        int l;
        CUR_TIME = {6'd1, 6'd2, 6'd3};
        press(B_MODE, 1, l);
        press(B_MODE, 1, l);
        press(B_MODE, 1, l);
        press(B_OK | B_UP, 1, l);
        checks++; if (l !== 1) begin errors++; $display("FAIL ok_up_load: got %0d expected 1", l); end
        checks++; if (LOAD_TIME[5:0] !== 6'd3) begin errors++; $display("FAIL ok_up_sec: got %0d expected 3", LOAD_TIME[5:0]); end
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL ok_up_state: got %0d expected 0", STATE); end
        press(B_MODE, 1, l);
        press(B_MODE, 1, l);
        press(B_MODE, 1, l);
        press(B_UP, 100, l);
        checks++; if (LOAD_TIME[5:0] !== 6'd4) begin errors++; $display("FAIL held_up: got %0d expected 4", LOAD_TIME[5:0]); end
        press(B_MODE | B_UP | B_DN, 1, l);
        checks++; if (STATE !== 4'(m_mode) || LOAD_TIME !== exp_time()) begin errors++; $display("FAIL mode_priority: got %0d/%h expected %0d/%h", STATE, LOAD_TIME, m_mode, exp_time()); end
        press(B_OK, 1, l);
    endtask

    task automatic test_reset_held();
        int l, base;
        CUR_TIME = {6'd8, 6'd8, 6'd8};
        press(B_MODE, 1, l);
        press(B_UP, 1, l);
        base = load_total;
        @(negedge CLK); BTN_MODE = 1'b1;
        @(posedge CLK); #2 RESETN = 1'b0;
        #1;
        model_reset();
        checks++; if (STATE !== 4'd0 || LOAD_TIME !== 18'd0 || TZ_OFS !== 5'd0) begin errors++; $display("FAIL async_reset: got %0d/%h/%b expected 0/0/0", STATE, LOAD_TIME, TZ_OFS); end
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        repeat (5) @(negedge CLK);
        checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL held_through_reset: got %0d expected 0", STATE); end
        checks++; if (load_total !== base) begin errors++; $display("FAIL reset_no_load: got %0d loads expected 0", load_total - base); end
        drive(0);
        repeat (2) @(negedge CLK);
        press(B_MODE, 1, l);
        checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL press_after_release: got %0d expected 1", STATE); end
    endtask

    task automatic test_random();
        int l, mask;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) CUR_TIME = 18'($urandom_range(0, 262143));
            if ($urandom_range(0, 3) == 0) begin
                tick();
                l = 0;
                exp_loads = 0;
            end else begin
                mask = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : (1 << $urandom_range(0, 3));
                press(mask, int'($urandom_range(1, 4)), l);
            end
            checks++;
            if (STATE !== 4'(m_mode) || LOAD_TIME !== exp_time() || TZ_OFS !== 5'(m_tz) || l !== exp_loads)
            begin
                errors++;
                $display("FAIL random_%0d: got st=%0d t=%h tz=%b ld=%0d expected st=%0d t=%h tz=%b ld=%0d",
                         i, STATE, LOAD_TIME, TZ_OFS, l, m_mode, exp_time(), 5'(m_tz), exp_loads);
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_wrap();
        test_timeout();
        test_priority_hold();
        test_reset_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_setup_ctrl.md
CLOCK_SETUP_CTRL -- requirements
Module: clock_setup_ctrl

Interface
REQ-001 Parameter: TIMEOUT_S, 10, number of TICK pulses without an accepted button action before an edit is abandoned (range 1..63).
REQ-002 Port: CLK  in  1  system clock; reset RESETN, asynchronous, active-low; clock CLK.
REQ-003 Port: RESETN  in  1  asynchronous active-low reset.
REQ-004 Port: TICK  in  1  one-cycle 1 Hz strobe, synchronous to CLK.
REQ-005 Port: BTN_MODE, BTN_UP, BTN_DOWN, BTN_OK  in  1 each  debounced active-high button levels.
REQ-006 Port: CUR_TIME  in  18  running time {hour[17:12], min[11:6], sec[5:0]} from the time counter.
REQ-007 Port: STATE  out  4  controller state, driven to the time counter.
REQ-008 Port: LOAD  out  1  one-cycle strobe; the counter loads LOAD_TIME when it is high.
REQ-009 Port: LOAD_TIME  out  18  edit registers {EH, EM, ES}; also serves as the live preview during edit.
REQ-010 Port: TZ_OFS  out  5  committed timezone offset, two's complement, range -12..+14.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 Each button SHALL be rising-edge detected with a one-flop history; the action SHALL take effect on the edge after the first high sample (2-edge latency).
REQ-013 When several edges occur in one cycle, only one SHALL be acted on, with priority OK > MODE > UP > DOWN.
REQ-014 States: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3, TZ_SETUP=4; other encodings SHALL recover to RUN on the next cycle.
REQ-015 RUN: MODE SHALL go to SET_HOUR and capture CUR_TIME into EH/EM/ES, and TZ_OFS into the edit TZ (ET); any field out of range SHALL capture as 0; UP, DOWN and OK SHALL be ignored.
REQ-016 SET_HOUR: UP/DOWN SHALL change EH by ±1 with wrap 23<->0; MODE SHALL go to SET_MIN.
REQ-017 SET_MIN: UP/DOWN SHALL change EM by ±1 with wrap 59<->0; MODE SHALL go to SET_SEC.
REQ-018 SET_SEC: UP/DOWN SHALL change ES by ±1 with wrap 59<->0; MODE SHALL go to TZ_SETUP.
REQ-019 TZ_SETUP: UP/DOWN SHALL change ET by ±1 with wrap +14<->-12; MODE SHALL go to SET_HOUR.
REQ-020 OK in any edit state SHALL do all of the following in the same cycle: assert LOAD for exactly 1 cycle, set TZ_OFS<=ET, and set STATE<=RUN.
REQ-021 Timeout counter: cleared on entry to an edit state and on every accepted button action; incremented on TICK in edit states.
REQ-022 When the timeout counter reaches TIMEOUT_S, the controller SHALL return to RUN with no LOAD; ET is discarded and TZ_OFS is unchanged.
REQ-023 When TICK and an accepted action occur in the same cycle, the counter SHALL clear and the tick is not counted.
REQ-024 LOAD SHALL never be asserted in RUN except in the commit cycle, and SHALL never be asserted on two consecutive cycles.
REQ-025 A button held across multiple cycles SHALL produce exactly one action.

Reset
REQ-026 On RESETN low: STATE=RUN, LOAD=0, LOAD_TIME=0, TZ_OFS=0, ET=0, timeout counter=0.
REQ-027 On RESETN low, button history flops SHALL reset to 1, so a button held through reset produces no action until it is released and pressed again.
REQ-028 Reset asserted mid-edit SHALL abandon the edit, produce no LOAD, and leave TZ_OFS=0.

Structure
REQ-029 Shared header clock_defs SHALL hold the state encodings, HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, TZ_MIN=-12, TZ_MAX=+14, and the time field bit positions; the time counter SHALL use the same header.
REQ-030 Sub-module btn_edge (history flop plus rising-edge pulse, reset-to-1) SHALL be instantiated once per button.

Verification
REQ-031 CUR_TIME=10:20:30, press MODE, press UP ×2, press OK -> LOAD high for exactly 1 cycle with LOAD_TIME=12:20:30, then STATE=RUN.
REQ-032 In SET_HOUR with EH=0, press DOWN -> EH=23; in SET_MIN with EM=59, press UP -> EM=0.
REQ-033 In TZ_SETUP with ET=+14, press UP -> ET=-12; press OK -> TZ_OFS=5'b10100 (-12).
REQ-034 TIMEOUT_S=3, enter SET_MIN, apply 3 TICKs with no button -> STATE=RUN, no LOAD, TZ_OFS unchanged.
REQ-035 OK and UP rising in the same cycle in SET_SEC -> commit only, ES unchanged; UP held for 100 cycles -> single increment.
REQ-036 BTN_MODE held high through reset release -> STATE stays RUN; a subsequent release and press -> SET_HOUR.
